// File: rtl/cmp_alarm_tracker.sv
// Consumes the comparator L/E/G result: one-hot qualification, hold/release alarm
// hysteresis FSM, and saturating per-outcome statistics counters.
module cmp_alarm_tracker #(
    parameter int unsigned HOLD_CNT = 4,
    parameter int unsigned REL_CNT  = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmp_valid,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             clear,
    output logic             alarm_hi,
    output logic             alarm_lo,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_gt
);

    typedef enum logic [2:0] {
        NORM   = 3'd0,
        PEND_G = 3'd1,
        HIGH   = 3'd2,
        PEND_L = 3'd3,
        LOW    = 3'd4
    } state_t;

    localparam logic [7:0] HOLD8 = 8'(HOLD_CNT);
    localparam logic [7:0] REL8  = 8'(REL_CNT);

    state_t           st_q, st_d;
    logic [7:0]       run_q, run_d;
    logic [7:0]       run_inc;
    logic             err_q;
    logic [CNT_W-1:0] cnt_lt_q, cnt_eq_q, cnt_gt_q;
    logic [2:0]       res;
    logic             onehot;
    logic             accept;

    assign res     = {cmp_lt, cmp_eq, cmp_gt};
    assign onehot  = (res == 3'b100) || (res == 3'b010) || (res == 3'b001);
    assign accept  = cmp_valid && onehot;
    assign run_inc = run_q + 8'd1;

    always_comb begin
        st_d  = st_q;
        run_d = run_q;
        case (st_q)
            NORM: begin
                if (accept && cmp_gt) begin
                    st_d  = (HOLD8 == 8'd1) ? HIGH : PEND_G;
                    run_d = (HOLD8 == 8'd1) ? 8'd0 : 8'd1;
                end else if (accept && cmp_lt) begin
                    st_d  = (HOLD8 == 8'd1) ? LOW : PEND_L;
                    run_d = (HOLD8 == 8'd1) ? 8'd0 : 8'd1;
                end
            end
            PEND_G: begin
                if (accept && cmp_gt) begin
                    if (run_inc == HOLD8) begin
                        st_d  = HIGH;
                        run_d = 8'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end else if (accept && cmp_lt) begin
                    st_d  = (HOLD8 == 8'd1) ? LOW : PEND_L;
                    run_d = (HOLD8 == 8'd1) ? 8'd0 : 8'd1;
                end else if (accept) begin
                    st_d  = NORM;
                    run_d = 8'd0;
                end
            end
            PEND_L: begin
                if (accept && cmp_lt) begin
                    if (run_inc == HOLD8) begin
                        st_d  = LOW;
                        run_d = 8'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end else if (accept && cmp_gt) begin
                    st_d  = (HOLD8 == 8'd1) ? HIGH : PEND_G;
                    run_d = (HOLD8 == 8'd1) ? 8'd0 : 8'd1;
                end else if (accept) begin
                    st_d  = NORM;
                    run_d = 8'd0;
                end
            end
            // Release always passes through NORM; an opposite result only counts toward release.
            HIGH: begin
                if (accept && cmp_gt) begin
                    run_d = 8'd0;
                end else if (accept) begin
                    if (run_inc == REL8) begin
                        st_d  = NORM;
                        run_d = 8'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end
            end
            LOW: begin
                if (accept && cmp_lt) begin
                    run_d = 8'd0;
                end else if (accept) begin
                    if (run_inc == REL8) begin
                        st_d  = NORM;
                        run_d = 8'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end
            end
            default: begin
                st_d  = NORM;
                run_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= NORM;
            run_q    <= '0;
            err_q    <= 1'b0;
            cnt_lt_q <= '0;
            cnt_eq_q <= '0;
            cnt_gt_q <= '0;
        end else if (clear) begin
            st_q     <= NORM;
            run_q    <= '0;
            err_q    <= 1'b0;
            cnt_lt_q <= '0;
            cnt_eq_q <= '0;
            cnt_gt_q <= '0;
        end else begin
            st_q  <= st_d;
            run_q <= run_d;
            err_q <= cmp_valid && !onehot;
            if (accept && cmp_lt && (cnt_lt_q != '1)) cnt_lt_q <= cnt_lt_q + CNT_W'(1);
            if (accept && cmp_eq && (cnt_eq_q != '1)) cnt_eq_q <= cnt_eq_q + CNT_W'(1);
            if (accept && cmp_gt && (cnt_gt_q != '1)) cnt_gt_q <= cnt_gt_q + CNT_W'(1);
        end
    end

    assign state    = st_q;
    assign alarm_hi = (st_q == HIGH);
    assign alarm_lo = (st_q == LOW);
    assign err      = err_q;
    assign cnt_lt   = cnt_lt_q;
    assign cnt_eq   = cnt_eq_q;
    assign cnt_gt   = cnt_gt_q;

endmodule

// File: tb/tb_cmp_alarm_tracker.sv
// Directed bench for cmp_alarm_tracker: vector table plus hand-written corner sequences.
module tb_cmp_alarm_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmp_valid, cmp_lt, cmp_eq, cmp_gt, clear;
    logic       alarm_hi, alarm_lo, err;
    logic [2:0] state;
    logic [7:0] cnt_lt, cnt_eq, cnt_gt;
    logic       alarm_hi2, alarm_lo2, err2;
    logic [2:0] state2;
    logic [1:0] cnt_lt2, cnt_eq2, cnt_gt2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    cmp_alarm_tracker #(.HOLD_CNT(4), .REL_CNT(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
        .cmp_gt(cmp_gt), .clear(clear), .alarm_hi(alarm_hi), .alarm_lo(alarm_lo),
        .state(state), .err(err), .cnt_lt(cnt_lt), .cnt_eq(cnt_eq), .cnt_gt(cnt_gt)
    );

    cmp_alarm_tracker #(.HOLD_CNT(4), .REL_CNT(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
        .cmp_gt(cmp_gt), .clear(clear), .alarm_hi(alarm_hi2), .alarm_lo(alarm_lo2),
        .state(state2), .err(err2), .cnt_lt(cnt_lt2), .cnt_eq(cnt_eq2), .cnt_gt(cnt_gt2)
    );

    typedef struct {
        logic       v, l, e, g, c;
        logic [2:0] st;
        logic       er;
        logic [7:0] clt, ceq, cgt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic e, input logic g, input logic c);
        cmp_valid = v; cmp_lt = l; cmp_eq = e; cmp_gt = g; clear = c;
    endtask

    task automatic step(input logic v, input logic l, input logic e, input logic g, input logic c);
        drive(v, l, e, g, c);
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [2:0] st, input logic er,
                              input logic [7:0] clt, input logic [7:0] ceq, input logic [7:0] cgt);
        check({tag, " state"},    state,    st);
        check({tag, " alarm_hi"}, alarm_hi, (st == 3'd2));
        check({tag, " alarm_lo"}, alarm_lo, (st == 3'd4));
        check({tag, " err"},      err,      er);
        check({tag, " cnt_lt"},   cnt_lt,   clt);
        check({tag, " cnt_eq"},   cnt_eq,   ceq);
        check({tag, " cnt_gt"},   cnt_gt,   cgt);
    endtask

    function automatic vec_t mk(logic v, logic l, logic e, logic g, logic c, logic [2:0] st,
                                logic er, logic [7:0] clt, logic [7:0] ceq, logic [7:0] cgt);
        vec_t r;
        r.v = v; r.l = l; r.e = e; r.g = g; r.c = c;
        r.st = st; r.er = er; r.clt = clt; r.ceq = ceq; r.cgt = cgt;
        return r;
    endfunction

    initial begin
        // 4 gt back-to-back reach HIGH
        vecs.push_back(mk(1,0,0,1,0, 3'd1,0, 0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd1,0, 0,0,2));
        vecs.push_back(mk(1,0,0,1,0, 3'd1,0, 0,0,3));
        vecs.push_back(mk(1,0,0,1,0, 3'd2,0, 0,0,4));
        // eq, gt, eq, lt releases HIGH to NORM, never LOW
        vecs.push_back(mk(1,0,1,0,0, 3'd2,0, 0,1,4));
        vecs.push_back(mk(1,0,0,1,0, 3'd2,0, 0,1,5));
        vecs.push_back(mk(1,0,1,0,0, 3'd2,0, 0,2,5));
        vecs.push_back(mk(1,1,0,0,0, 3'd0,0, 1,2,5));
        // illegal combos pulse err only
        vecs.push_back(mk(1,1,1,0,0, 3'd0,1, 1,2,5));
        vecs.push_back(mk(0,0,0,0,0, 3'd0,0, 1,2,5));
        vecs.push_back(mk(1,0,0,0,0, 3'd0,1, 1,2,5));
        vecs.push_back(mk(1,1,0,1,0, 3'd0,1, 1,2,5));
        vecs.push_back(mk(0,1,1,1,0, 3'd0,0, 1,2,5));
        // 3 lt then eq aborts pending
        vecs.push_back(mk(1,1,0,0,0, 3'd3,0, 2,2,5));
        vecs.push_back(mk(1,1,0,0,0, 3'd3,0, 3,2,5));
        vecs.push_back(mk(1,1,0,0,0, 3'd3,0, 4,2,5));
        vecs.push_back(mk(1,0,1,0,0, 3'd0,0, 4,3,5));
        // 4 lt separated by 2 idle cycles reach LOW
        vecs.push_back(mk(1,1,0,0,0, 3'd3,0, 5,3,5));
        vecs.push_back(mk(0,0,0,1,0, 3'd3,0, 5,3,5));
        vecs.push_back(mk(0,0,0,0,0, 3'd3,0, 5,3,5));
        vecs.push_back(mk(1,1,0,0,0, 3'd3,0, 6,3,5));
        vecs.push_back(mk(0,0,0,0,0, 3'd3,0, 6,3,5));
        vecs.push_back(mk(0,0,0,0,0, 3'd3,0, 6,3,5));
        vecs.push_back(mk(1,1,0,0,0, 3'd3,0, 7,3,5));
        vecs.push_back(mk(0,0,0,0,0, 3'd3,0, 7,3,5));
        vecs.push_back(mk(0,0,0,0,0, 3'd3,0, 7,3,5));
        vecs.push_back(mk(1,1,0,0,0, 3'd4,0, 8,3,5));
        vecs.push_back(mk(0,0,0,0,0, 3'd4,0, 8,3,5));
        // single gt in LOW does not release (REL=2)
        vecs.push_back(mk(1,0,0,1,0, 3'd4,0, 8,3,6));
        // clear beats an illegal sample: no err
        vecs.push_back(mk(1,1,1,1,1, 3'd0,0, 0,0,0));

        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #23;
        check_main("reset", 3'd0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_main("post-reset idle", 3'd0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].l, vecs[i].e, vecs[i].g, vecs[i].c);
            check_main($sformatf("vec%0d", i), vecs[i].st, vecs[i].er,
                       vecs[i].clt, vecs[i].ceq, vecs[i].cgt);
        end

        // CNT_W=2 saturation, then clear with a simultaneous gt
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 1, 0, 0);
            check($sformatf("sat eq%0d cnt_eq2", i), cnt_eq2, (i > 3) ? 3 : i);
            check($sformatf("sat eq%0d cnt_eq", i), cnt_eq, i);
        end
        step(1, 0, 0, 1, 1);
        check("clear cnt_eq2", cnt_eq2, 0);
        check("clear cnt_gt2", cnt_gt2, 0);
        check("clear cnt_lt2", cnt_lt2, 0);
        check("clear state2",  state2,  0);
        check_main("clear+gt", 3'd0, 0, 0, 0, 0);

        // async reset mid-PEND_G discards the partial run
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check_main("pre-reset pend", 3'd1, 0, 0, 0, 2);
        drive(0, 0, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_main("async reset", 3'd0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0, 1, 0);
            check_main($sformatf("after reset gt%0d", i), (i == 4) ? 3'd2 : 3'd1, 0, 0, 0, i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
